// File: rtl/riscv_soft_operand_stage_pkg.sv
// Shared encodings and widths for the soft RISC-V operand-fetch stage.
package riscv_soft_operand_stage_pkg;

   // Default operand data width
   localparam int unsigned XPR_LEN    = 32;
   // Architectural register address width
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned SEL_W      = 2;

   // ALU source select encoding
   localparam logic [SEL_W-1:0] ALU_SRC_IMM  = 2'd0;
   localparam logic [SEL_W-1:0] ALU_SRC_PC   = 2'd1;
   localparam logic [SEL_W-1:0] ALU_SRC_REG  = 2'd2;
   localparam logic [SEL_W-1:0] ALU_SRC_ZERO = 2'd3;

   // Register x0 is hardwired to zero and must never be forwarded
   function automatic logic is_fwd_reg(input logic [REG_ADDR_W-1:0] rs);
      return rs != '0;
   endfunction

endpackage

// File: rtl/riscv_soft_bypass_select.sv
// Per-channel operand source mux with priority bypass and load-use hazard flag.
module riscv_soft_bypass_select #(
   parameter int unsigned XPR_LEN = 32,
   parameter int unsigned NUM_BYP = 3
) (
   input  logic [riscv_soft_operand_stage_pkg::SEL_W-1:0]              sel,
   input  logic [riscv_soft_operand_stage_pkg::REG_ADDR_W-1:0]         rs,
   input  logic [XPR_LEN-1:0]                                          reg_data,
   input  logic [XPR_LEN-1:0]                                          imm,
   input  logic [XPR_LEN-1:0]                                          pc,
   input  logic [NUM_BYP-1:0]                                          byp_valid,
   input  logic [riscv_soft_operand_stage_pkg::REG_ADDR_W*NUM_BYP-1:0] byp_rd,
   input  logic [XPR_LEN*NUM_BYP-1:0]                                  byp_data,
   input  logic [NUM_BYP-1:0]                                          byp_data_ready,
   output logic [XPR_LEN-1:0]                                          operand_c,
   output logic                                                        fwd_c,
   output logic                                                        hazard_c
);

   import riscv_soft_operand_stage_pkg::*;

   logic               hit;
   logic [XPR_LEN-1:0] hit_data;
   logic               hit_ready;

   // Priority match: scan oldest to youngest so the youngest match wins
   always_comb begin
      hit       = 1'b0;
      hit_data  = '0;
      hit_ready = 1'b0;
      for (int k = int'(NUM_BYP) - 1; k >= 0; k--) begin
         if (byp_valid[k] && (byp_rd[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
            hit       = 1'b1;
            hit_data  = byp_data[k*XPR_LEN +: XPR_LEN];
            hit_ready = byp_data_ready[k];
         end
      end
   end

   // Source select; bypass only applies to real registers (not x0)
   always_comb begin
      operand_c = '0;
      fwd_c     = 1'b0;
      hazard_c  = 1'b0;
      case (sel)
         ALU_SRC_IMM: operand_c = imm;
         ALU_SRC_PC:  operand_c = pc;
         ALU_SRC_REG: begin
            if (is_fwd_reg(rs) && hit) begin
               operand_c = hit_data;
               fwd_c     = 1'b1;
               hazard_c  = !hit_ready;
            end else begin
               operand_c = reg_data;
            end
         end
         default:     operand_c = '0;
      endcase
   end

endmodule

// File: rtl/riscv_soft_operand_stage.sv
// Operand-fetch stage: NUM_SRC bypassed operand channels feeding a registered valid/ready slot.
module riscv_soft_operand_stage #(
   parameter int unsigned XPR_LEN = 32,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned NUM_BYP = 3,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                                                        clk,
   input  logic                                                        reset_n,
   input  logic                                                        in_valid,
   output logic                                                        in_ready,
   input  logic [riscv_soft_operand_stage_pkg::SEL_W*NUM_SRC-1:0]      src_sel,
   input  logic [riscv_soft_operand_stage_pkg::REG_ADDR_W*NUM_SRC-1:0] src_rs,
   input  logic [XPR_LEN*NUM_SRC-1:0]                                  src_reg_data,
   input  logic [XPR_LEN-1:0]                                          imm,
   input  logic [XPR_LEN-1:0]                                          pc,
   input  logic [NUM_BYP-1:0]                                          byp_valid,
   input  logic [riscv_soft_operand_stage_pkg::REG_ADDR_W*NUM_BYP-1:0] byp_rd,
   input  logic [XPR_LEN*NUM_BYP-1:0]                                  byp_data,
   input  logic [NUM_BYP-1:0]                                          byp_data_ready,
   input  logic                                                        flush,
   output logic                                                        out_valid,
   input  logic                                                        out_ready,
   output logic [XPR_LEN*NUM_SRC-1:0]                                  out_data,
   output logic [NUM_SRC-1:0]                                          out_fwd,
   output logic                                                        hazard_stall,
   output logic [CNT_W-1:0]                                            stall_count
);

   import riscv_soft_operand_stage_pkg::*;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [XPR_LEN*NUM_SRC-1:0] sel_data_c;
   logic [NUM_SRC-1:0]         sel_fwd_c;
   logic [NUM_SRC-1:0]         chan_hazard_c;
   logic                       accept_c;

   // One bypass/select network per operand channel
   for (genvar c = 0; c < int'(NUM_SRC); c++) begin : g_chan
      riscv_soft_bypass_select #(
         .XPR_LEN (XPR_LEN),
         .NUM_BYP (NUM_BYP)
      ) u_sel (
         .sel            (src_sel[c*SEL_W +: SEL_W]),
         .rs             (src_rs[c*REG_ADDR_W +: REG_ADDR_W]),
         .reg_data       (src_reg_data[c*XPR_LEN +: XPR_LEN]),
         .imm            (imm),
         .pc             (pc),
         .byp_valid      (byp_valid),
         .byp_rd         (byp_rd),
         .byp_data       (byp_data),
         .byp_data_ready (byp_data_ready),
         .operand_c      (sel_data_c[c*XPR_LEN +: XPR_LEN]),
         .fwd_c          (sel_fwd_c[c]),
         .hazard_c       (chan_hazard_c[c])
      );
   end

   // Handshake: stall on load-use, back-pressure from execute, or flush
   always_comb begin
      hazard_stall = in_valid && (|chan_hazard_c);
      in_ready     = !hazard_stall && (!out_valid || out_ready) && !flush;
      accept_c     = in_valid && in_ready;
   end

   // Output slot; flush wins over accept and consume
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_fwd   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept_c) begin
         out_valid <= 1'b1;
         out_data  <= sel_data_c;
         out_fwd   <= sel_fwd_c;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating count of hazard-stall cycles not masked by flush
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_count <= '0;
      end else if (hazard_stall && !flush && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_riscv_soft_operand_stage.sv
// Directed self-checking bench for riscv_soft_operand_stage (CNT_W=4 to reach saturation).
module tb_riscv_soft_operand_stage;

   localparam int unsigned XL = 32;
   localparam int unsigned NS = 2;
   localparam int unsigned NB = 3;
   localparam int unsigned CW = 4;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           in_valid;
   logic           in_ready;
   logic [2*NS-1:0]  src_sel;
   logic [5*NS-1:0]  src_rs;
   logic [XL*NS-1:0] src_reg_data;
   logic [XL-1:0]    imm;
   logic [XL-1:0]    pc;
   logic [NB-1:0]    byp_valid;
   logic [5*NB-1:0]  byp_rd;
   logic [XL*NB-1:0] byp_data;
   logic [NB-1:0]    byp_data_ready;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XL*NS-1:0] out_data;
   logic [NS-1:0]    out_fwd;
   logic             hazard_stall;
   logic [CW-1:0]    stall_count;

   int total = 0;
   int bad   = 0;

   riscv_soft_operand_stage #(
      .XPR_LEN (XL),
      .NUM_SRC (NS),
      .NUM_BYP (NB),
      .CNT_W   (CW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .src_sel        (src_sel),
      .src_rs         (src_rs),
      .src_reg_data   (src_reg_data),
      .imm            (imm),
      .pc             (pc),
      .byp_valid      (byp_valid),
      .byp_rd         (byp_rd),
      .byp_data       (byp_data),
      .byp_data_ready (byp_data_ready),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_fwd        (out_fwd),
      .hazard_stall   (hazard_stall),
      .stall_count    (stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n        = 1'b0;
      in_valid       = 1'b0;
      src_sel        = '0;
      src_rs         = '0;
      src_reg_data   = '0;
      imm            = '0;
      pc             = '0;
      byp_valid      = '0;
      byp_rd         = '0;
      byp_data       = '0;
      byp_data_ready = '0;
      flush          = 1'b0;
      out_ready      = 1'b0;

      // Reset state
      do_reset();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_fwd", 64'(out_fwd), 64'd0);
      chk("rst_cnt", 64'(stall_count), 64'd0);

      // ch0=IMM, ch1=PC
      src_sel   = {2'd1, 2'd0};
      imm       = 32'h1234;
      pc        = 32'h80;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("imm_pc_ready", 64'(in_ready), 64'd1);
      chk("imm_pc_haz", 64'(hazard_stall), 64'd0);
      tick();
      chk("imm_pc_valid", 64'(out_valid), 64'd1);
      chk("imm_pc_data", 64'(out_data), {32'h80, 32'h1234});
      chk("imm_pc_fwd", 64'(out_fwd), 64'd0);

      // ch0=REG rs5: youngest bypass (k0) beats older k2; ch1=ZERO
      src_sel        = {2'd3, 2'd2};
      src_rs         = {5'd0, 5'd5};
      src_reg_data   = {32'hFFFF, 32'hDEAD};
      byp_valid      = 3'b101;
      byp_rd         = {5'd5, 5'd0, 5'd5};
      byp_data       = {32'hAA, 32'h0, 32'hBB};
      byp_data_ready = 3'b111;
      tick();
      chk("byp_prio_data", 64'(out_data), {32'h0, 32'hBB});
      chk("byp_prio_fwd", 64'(out_fwd), 64'b01);
      chk("byp_prio_valid", 64'(out_valid), 64'd1);

      // x0 never forwarded even on a matching bypass
      src_rs    = {5'd0, 5'd0};
      byp_valid = 3'b001;
      byp_rd    = {5'd9, 5'd9, 5'd0};
      tick();
      chk("x0_data", 64'(out_data), {32'h0, 32'hDEAD});
      chk("x0_fwd", 64'(out_fwd), 64'b00);

      // non-REG channel ignores a pending matching bypass
      src_sel        = {2'd3, 2'd0};
      src_rs         = {5'd0, 5'd5};
      byp_rd         = {5'd9, 5'd9, 5'd5};
      byp_data_ready = 3'b000;
      #1;
      chk("nonreg_haz", 64'(hazard_stall), 64'd0);

      // Load-use: ch1=REG rs7, young k0 pending overrides older ready k1
      do_reset();
      src_sel        = {2'd2, 2'd3};
      src_rs         = {5'd7, 5'd0};
      byp_valid      = 3'b011;
      byp_rd         = {5'd0, 5'd7, 5'd7};
      byp_data       = {32'h0, 32'h66, 32'h55};
      byp_data_ready = 3'b010;
      in_valid       = 1'b1;
      out_ready      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lu_haz", 64'(hazard_stall), 64'd1);
         chk("lu_inrdy", 64'(in_ready), 64'd0);
         tick();
      end
      chk("lu_cnt", 64'(stall_count), 64'd3);
      chk("lu_novalid", 64'(out_valid), 64'd0);
      byp_data_ready = 3'b011;
      #1;
      chk("lu_rel_haz", 64'(hazard_stall), 64'd0);
      tick();
      chk("lu_valid", 64'(out_valid), 64'd1);
      chk("lu_data", 64'(out_data), {32'h55, 32'h0});
      chk("lu_fwd", 64'(out_fwd), 64'b10);
      chk("lu_cnt_hold", 64'(stall_count), 64'd3);

      // Back-pressure: slot holds while out_ready=0
      byp_valid = '0;
      src_sel   = {2'd1, 2'd0};
      imm       = 32'h111;
      pc        = 32'h222;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bp_inrdy", 64'(in_ready), 64'd0);
         tick();
         chk("bp_hold", 64'(out_data), {32'h55, 32'h0});
      end
      out_ready = 1'b1;
      #1;
      chk("bp_rel_inrdy", 64'(in_ready), 64'd1);
      tick();
      chk("b2b_0", 64'(out_data), {32'h222, 32'h111});
      imm = 32'h333;
      tick();
      chk("b2b_1", 64'(out_data), {32'h222, 32'h333});
      chk("b2b_valid", 64'(out_valid), 64'd1);

      // Flush kills slot, blocks capture, not counted as stall
      imm   = 32'h444;
      flush = 1'b1;
      #1;
      chk("fl_inrdy", 64'(in_ready), 64'd0);
      tick();
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_data", 64'(out_data), {32'h222, 32'h333});
      src_sel        = {2'd2, 2'd3};
      byp_valid      = 3'b001;
      byp_rd         = {5'd0, 5'd0, 5'd7};
      byp_data_ready = 3'b000;
      tick();
      chk("fl_cnt", 64'(stall_count), 64'd3);
      chk("fl_valid2", 64'(out_valid), 64'd0);
      flush = 1'b0;

      // Saturation then async reset mid-stall
      do_reset();
      src_sel   = {2'd1, 2'd0};
      byp_valid = '0;
      imm       = 32'h99;
      pc        = 32'h98;
      out_ready = 1'b0;
      tick();
      chk("sat_pre_valid", 64'(out_valid), 64'd1);
      src_sel   = {2'd2, 2'd3};
      byp_valid = 3'b001;
      repeat (21) tick();
      chk("sat_cnt", 64'(stall_count), 64'd15);
      chk("sat_haz", 64'(hazard_stall), 64'd1);
      chk("sat_data", 64'(out_data), {32'h98, 32'h99});
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_fwd", 64'(out_fwd), 64'd0);
      chk("arst_cnt", 64'(stall_count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_soft_operand_stage.md
Name: riscv_soft_operand_stage

Overview:
Parametrised operand-fetch stage for the soft RISC-V pipeline. It replaces the single-operand ALU source mux with NUM_SRC operand channels, each selecting among immediate, PC, register file and zero. Each channel has a priority bypass network over NUM_BYP in-flight writeback stages and load-use hazard detection. Results go into a registered valid/ready output slot, with flush support and a saturating stall counter. It sits between decode and execute.

Parameters:
XPR_LEN, 32, operand data width
NUM_SRC, 2, number of operand channels
NUM_BYP, 3, number of bypass sources; index 0 is youngest and has highest priority
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
src_sel  in  2*NUM_SRC  per-channel source select (ALU_SRC_* encoding)
src_rs  in  5*NUM_SRC  per-channel source register address
src_reg_data  in  XPR_LEN*NUM_SRC  per-channel register-file read data
imm  in  XPR_LEN  decoded immediate (shared by all channels)
pc  in  XPR_LEN  instruction PC (shared by all channels)
byp_valid  in  NUM_BYP  bypass stage k holds a register write
byp_rd  in  5*NUM_BYP  destination register of stage k
byp_data  in  XPR_LEN*NUM_BYP  write data of stage k
byp_data_ready  in  NUM_BYP  stage k data is final (0 = load still pending)
flush  in  1  kill the output slot and drop the input
out_valid  out  1  output slot holds operands
out_ready  in  1  execute consumes the slot
out_data  out  XPR_LEN*NUM_SRC  registered operands
out_fwd  out  NUM_SRC  registered: channel operand came from bypass
hazard_stall  out  1  combinational load-use stall indicator
stall_count  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, reset_n=0): out_valid=0, out_data=0, out_fwd=0, stall_count=0. Reset mid-transfer drops the slot contents.
- Per channel c, combinational operand selection:
  - IMM gives imm.
  - PC gives pc.
  - ZERO gives 0.
  - REG: if rs!=0, pick the lowest k with byp_valid[k] && byp_rd[k]==rs, and use byp_data[k] with fwd=1. Otherwise use src_reg_data with fwd=0. Register x0 is never forwarded.
- Channel hazard: sel==REG, rs!=0, a matching k exists, and byp_data_ready[k]==0 for the youngest match. Older ready matches do not override a younger pending one.
- hazard_stall = in_valid && (OR of channel hazards). Channels with sel!=REG never raise a hazard.
- in_ready = !hazard_stall && (!out_valid || out_ready) && !flush.
- accept = in_valid && in_ready. On accept: out_data and out_fwd capture the selected values and out_valid=1 on the next edge. Latency is 1 cycle.
- If out_valid && out_ready && !accept, out_valid goes to 0 next cycle. Consume and accept in the same cycle keeps out_valid=1 with the new data (full throughput).
- flush: out_valid goes to 0 next cycle. Flush overrides accept and out_ready. out_data and out_fwd hold their values (don't-care).
- When out_valid && !out_ready, the output slot holds stable; back-pressure propagates through in_ready.
- stall_count increments on each cycle with hazard_stall=1 && !flush. It saturates at 2^CNT_W-1 and never wraps.
- All operand arithmetic is pure selection at width XPR_LEN; no extension or truncation.

Decomposition:
- Shared package/header: ALU_SRC_IMM=2'd0, ALU_SRC_PC=2'd1, ALU_SRC_REG=2'd2, ALU_SRC_ZERO=2'd3; XPR_LEN; REG_ADDR_W=5.
- Sub-module riscv_soft_bypass_select: combinational per-channel source mux, priority bypass match and hazard flag. Instantiated NUM_SRC times in a generate loop.
- The top level holds the handshake, output register and stall counter.

Test Plan:
- Reset, then sel0=IMM with imm=0x1234 and sel1=PC with pc=0x80, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data ch0=0x1234, ch1=0x80, out_fwd=00.
- sel0=REG, rs=5; byp[2] rd=5 data=0xAA ready; byp[0] rd=5 data=0xBB ready -> ch0=0xBB, out_fwd[0]=1. With rs=0 and a byp rd=0 match -> src_reg_data, fwd=0.
- sel1=REG, rs=7; byp[0] rd=7 ready=0 for 3 cycles, then ready=1 data=0x55 -> hazard_stall and !in_ready for 3 cycles, stall_count=3, then accept with ch1=0x55.
- Hold out_ready=0 for 4 cycles with in_valid=1 -> out_data stable, in_ready=0. Release -> back-to-back accepts, one per cycle.
- Assert flush while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no capture, stall_count unchanged.
- Force a hazard for 2^CNT_W+5 cycles (CNT_W=4) -> stall_count saturates at 15. Pulse reset_n low mid-stall -> all outputs 0 immediately.
